accum_sequencer: RTL and testbench
==================================

// Module: accum_sequencer
// PURPOSE
//  Sequences the correlator's read-modify-write visibility accumulator across one integration.
//  Counts partial-sum beats into frames of PAIRS words, flagging the first frame so
//  the accumulator overwrites instead of adding. Waits for the write-back pipeline
//  to settle, then drains the visibility SRAM as a backpressured AXI4-Stream-like
//  output. Sits between the correlator cores, the accumulator and the readout bus.
// PARAMETERS
//  CORES  18  correlator cores; PAIRS = CORES*TRATE (localparam) words per frame
//  TRATE  30  time-multiplex rate per core
//  NBITS  5   core-index bits; PBITS = NBITS+TBITS address bits
//  TBITS  5   multiplex-index bits
//  WIDTH  36  accumulated visibility width (per re/im component)
//  CBITS  16  frames-per-integration counter width
//  FLUSH  3   write-back settle cycles after the last accumulate beat
// PORTS
//  clock_i      in   1        system clock
//  reset_i      in   1        synchronous, active-high reset
//  start_i      in   1        pulse: begin integration; honoured only in IDLE
//  frames_i     in   CBITS    frames per integration, latched on start; 0 treated as 1
//  s_valid_i    in   1        partial-sum beat available from cores
//  s_ready_o    out  1        beat accepted (only in ACCUM)
//  acc_en_o     out  1        accumulator enable (= s_valid_i & s_ready_o)
//  acc_clr_o    out  1        first frame: accumulator writes psum, ignores SRAM
//  acc_addr_o   out  PBITS    pair address for the accepted beat
//  rd_en_o      out  1        SRAM drain read strobe
//  rd_addr_o    out  PBITS    SRAM drain read address
//  rd_data_i    in   2*WIDTH  {im,re}; valid exactly 1 cycle after rd_en_o
//  m_valid_o    out  1        drain word valid
//  m_ready_i    in   1        downstream ready
//  m_data_o     out  2*WIDTH  {im,re} visibility
//  m_last_o     out  1        with m_valid_o on word PAIRS-1
//  busy_o       out  1        state != IDLE
//  done_o       out  1        one-cycle pulse after the last drain handshake
// BEHAVIOUR
//  - Reset: state IDLE, counters 0, skid empty; every output 0 the cycle after reset_i.
//    Reset mid-operation aborts at once; nothing in flight survives.
//  - FSM IDLE->ACCUM (start_i) ->FLUSH (last beat of last frame) ->DRAIN (FLUSH cycles)
//    ->IDLE (last drain handshake, done_o=1 same cycle as the IDLE entry).
//  - ACCUM: s_ready_o=1; per accepted beat addr++, wrapping PAIRS-1->0 with frame++.
//    acc_clr_o=1 while frame==0. Transition after beat (frame==F-1, addr==PAIRS-1).
//    No beat -> no address/frame change (idle cycles allowed).
//  - FLUSH: s_ready_o=0, fixed FLUSH cycles, no SRAM reads.
//  - DRAIN: rd_en_o asserted when (outstanding read + skid occupancy) < 2; 2-entry skid
//    buffer gives full throughput with m_ready_i=1, no word lost/duplicated under any
//    m_ready_i pattern. m_data_o/m_valid_o/m_last_o held stable while m_valid_o & !m_ready_i.
//    rd_addr_o counts 0..PAIRS-1 once; reads stop after PAIRS-1.
//  - start_i outside IDLE ignored. start_i same cycle as reset_i: reset wins.
//  - frames_i sampled only on the start_i cycle; later changes have no effect.
//  - Latency: first m_valid_o no earlier than FLUSH+2 cycles after the last accepted beat.
// CONFIGURATION
//  ACC_SEQ_CONTINUOUS_EN defined: after drain, FSM goes DRAIN->ACCUM (not IDLE) reusing
//    the latched frame count; done_o still pulses; only reset_i returns to IDLE.
//  Not defined: single-shot, DRAIN->IDLE, new start_i needed per integration.
// TESTING
//  - Reset: hold reset_i 2 cycles mid-DRAIN -> all outputs 0, busy_o=0, next start_i works.
//  - frames_i=2, s_valid_i=1 always -> 1080 acc_en_o beats, acc_clr_o for first 540,
//    addr wraps 539->0, then 540 m_valid_o words, m_last_o on #540, one done_o.
//  - frames_i=0 -> behaves as 1: 540 beats all acc_clr_o=1, then full drain.
//  - m_ready_i random 30% duty during drain -> rd_data sequence 0..539 out in order, no
//    drops/duplicates, m_data_o stable while stalled.
//  - start_i pulsed during ACCUM and DRAIN -> ignored, frame count unchanged.
//  - ACC_SEQ_CONTINUOUS_EN: frames_i=1 -> two back-to-back integrations, busy_o stays 1,
//    two done_o pulses, acc_clr_o restarts on second integration.

Source files
------------

// File: rtl/accum_sequencer_if.sv
// Bundle of handshake and bus signals between accum_sequencer, the correlator
// cores, the accumulator, the visibility SRAM and the readout bus.
interface accum_sequencer_if #(
    parameter int PBITS = 10,
    parameter int WIDTH = 36,
    parameter int CBITS = 16
);
    logic                 start_i;
    logic [CBITS-1:0]     frames_i;
    logic                 s_valid_i;
    logic                 s_ready_o;
    logic                 acc_en_o;
    logic                 acc_clr_o;
    logic [PBITS-1:0]     acc_addr_o;
    logic                 rd_en_o;
    logic [PBITS-1:0]     rd_addr_o;
    logic [2*WIDTH-1:0]   rd_data_i;
    logic                 m_valid_o;
    logic                 m_ready_i;
    logic [2*WIDTH-1:0]   m_data_o;
    logic                 m_last_o;
    logic                 busy_o;
    logic                 done_o;

    modport master (
        input  start_i, frames_i, s_valid_i, rd_data_i, m_ready_i,
        output s_ready_o, acc_en_o, acc_clr_o, acc_addr_o, rd_en_o, rd_addr_o,
               m_valid_o, m_data_o, m_last_o, busy_o, done_o
    );

    modport slave (
        output start_i, frames_i, s_valid_i, rd_data_i, m_ready_i,
        input  s_ready_o, acc_en_o, acc_clr_o, acc_addr_o, rd_en_o, rd_addr_o,
               m_valid_o, m_data_o, m_last_o, busy_o, done_o
    );
endinterface

// File: rtl/accum_sequencer.sv
// Integration sequencer for the visibility accumulator: frame counting, write-back
// settle, then a backpressured SRAM drain. Define ACC_SEQ_CONTINUOUS_EN for free-running integrations.
module accum_sequencer #(
    parameter int CORES = 18,
    parameter int TRATE = 30,
    parameter int NBITS = 5,
    parameter int TBITS = 5,
    parameter int WIDTH = 36,
    parameter int CBITS = 16,
    parameter int FLUSH = 3
) (
    input  logic             clock_i,
    input  logic             reset_i,
    accum_sequencer_if.master bus
);
    localparam int PAIRS = CORES * TRATE;
    localparam int PBITS = NBITS + TBITS;
    localparam int FBITS = (FLUSH > 1) ? $clog2(FLUSH) : 1;
    localparam logic [PBITS-1:0] LAST_ADDR  = PBITS'(PAIRS - 1);
    localparam logic [FBITS-1:0] LAST_FLUSH = FBITS'(FLUSH - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_ACCUM, ST_FLUSH, ST_DRAIN} state_t;

    state_t             state_q, state_d;
    logic [PBITS-1:0]   addr_q, addr_d;
    logic [CBITS-1:0]   frame_q, frame_d;
    logic [CBITS-1:0]   frames_lat_q, frames_lat_d;
    logic [FBITS-1:0]   flush_cnt_q, flush_cnt_d;
    logic [PBITS-1:0]   rd_addr_q, rd_addr_d;
    logic               rd_fin_q, rd_fin_d;
    logic               pend_q, pend_d;
    logic [1:0]         cnt_q, cnt_d;
    logic [2*WIDTH-1:0] buf0_q, buf0_d;
    logic [2*WIDTH-1:0] buf1_q, buf1_d;
    logic [PBITS-1:0]   out_cnt_q, out_cnt_d;
    logic               done_q, done_d;

    logic beat, last_beat, pop, push, last_pop, rd_en;

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        frame_d      = frame_q;
        frames_lat_d = frames_lat_q;
        flush_cnt_d  = flush_cnt_q;
        rd_addr_d    = rd_addr_q;
        rd_fin_d     = rd_fin_q;
        out_cnt_d    = out_cnt_q;
        buf0_d       = buf0_q;
        buf1_d       = buf1_q;
        cnt_d        = cnt_q;
        done_d       = 1'b0;

        beat      = (state_q == ST_ACCUM) && bus.s_valid_i;
        last_beat = beat && (addr_q == LAST_ADDR) && (frame_q == frames_lat_q - 1'b1);
        pop       = (cnt_q != 2'd0) && bus.m_ready_i;
        push      = pend_q;
        last_pop  = pop && (out_cnt_q == LAST_ADDR);
        // Count the word leaving this cycle as free so the skid streams at full rate.
        rd_en     = (state_q == ST_DRAIN) && !rd_fin_q &&
                    ((2'(pend_q) + cnt_q - 2'(pop)) < 2'd2);
        pend_d    = rd_en;

        case (state_q)
            ST_IDLE: begin
                if (bus.start_i) begin
                    state_d      = ST_ACCUM;
                    frames_lat_d = (bus.frames_i == '0) ? CBITS'(1) : bus.frames_i;
                    addr_d       = '0;
                    frame_d      = '0;
                end
            end
            ST_ACCUM: begin
                if (beat) begin
                    if (addr_q == LAST_ADDR) begin
                        addr_d  = '0;
                        frame_d = frame_q + 1'b1;
                    end else begin
                        addr_d  = addr_q + 1'b1;
                    end
                end
                if (last_beat) begin
                    state_d     = ST_FLUSH;
                    flush_cnt_d = '0;
                end
            end
            ST_FLUSH: begin
                flush_cnt_d = flush_cnt_q + 1'b1;
                if (flush_cnt_q == LAST_FLUSH) begin
                    state_d   = ST_DRAIN;
                    rd_addr_d = '0;
                    rd_fin_d  = 1'b0;
                    out_cnt_d = '0;
                end
            end
            ST_DRAIN: begin
                if (rd_en) begin
                    if (rd_addr_q == LAST_ADDR) rd_fin_d  = 1'b1;
                    else                        rd_addr_d = rd_addr_q + 1'b1;
                end
                if (pop) out_cnt_d = out_cnt_q + 1'b1;
                if (last_pop) begin
                    done_d    = 1'b1;
                    rd_addr_d = '0;
                    rd_fin_d  = 1'b0;
                    out_cnt_d = '0;
`ifdef ACC_SEQ_CONTINUOUS_EN
                    state_d   = ST_ACCUM;
                    addr_d    = '0;
                    frame_d   = '0;
`else
                    state_d   = ST_IDLE;
`endif
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // buf0 is always the head of the skid; buf1 only fills under backpressure.
        case ({push, pop})
            2'b10: begin
                if (cnt_q == 2'd0) buf0_d = bus.rd_data_i;
                else               buf1_d = bus.rd_data_i;
                cnt_d = cnt_q + 2'd1;
            end
            2'b01: begin
                buf0_d = buf1_q;
                cnt_d  = cnt_q - 2'd1;
            end
            2'b11: begin
                if (cnt_q == 2'd1) begin
                    buf0_d = bus.rd_data_i;
                end else begin
                    buf0_d = buf1_q;
                    buf1_d = bus.rd_data_i;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q      <= ST_IDLE;
            addr_q       <= '0;
            frame_q      <= '0;
            frames_lat_q <= '0;
            flush_cnt_q  <= '0;
            rd_addr_q    <= '0;
            rd_fin_q     <= 1'b0;
            pend_q       <= 1'b0;
            cnt_q        <= 2'd0;
            buf0_q       <= '0;
            buf1_q       <= '0;
            out_cnt_q    <= '0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            frame_q      <= frame_d;
            frames_lat_q <= frames_lat_d;
            flush_cnt_q  <= flush_cnt_d;
            rd_addr_q    <= rd_addr_d;
            rd_fin_q     <= rd_fin_d;
            pend_q       <= pend_d;
            cnt_q        <= cnt_d;
            buf0_q       <= buf0_d;
            buf1_q       <= buf1_d;
            out_cnt_q    <= out_cnt_d;
            done_q       <= done_d;
        end
    end

    assign bus.s_ready_o  = (state_q == ST_ACCUM);
    assign bus.acc_en_o   = beat;
    assign bus.acc_clr_o  = (state_q == ST_ACCUM) && (frame_q == '0);
    assign bus.acc_addr_o = addr_q;
    assign bus.rd_en_o    = rd_en;
    assign bus.rd_addr_o  = rd_addr_q;
    assign bus.m_valid_o  = (cnt_q != 2'd0);
    assign bus.m_data_o   = (cnt_q != 2'd0) ? buf0_q : '0;
    assign bus.m_last_o   = (cnt_q != 2'd0) && (out_cnt_q == LAST_ADDR);
    assign bus.busy_o     = (state_q != ST_IDLE);
    assign bus.done_o     = done_q;
endmodule

// File: tb/tb_accum_sequencer.sv
// Directed bench for accum_sequencer: vector table of integrations plus reset sequences.
module tb_accum_sequencer;
    localparam int PAIRS = 540;
    localparam int PBITS = 10;
    localparam int WIDTH = 36;
    localparam int CBITS = 16;
    localparam int FLUSH = 3;

    logic clock_i = 1'b0;
    logic reset_i = 1'b1;

    accum_sequencer_if #(.PBITS(PBITS), .WIDTH(WIDTH), .CBITS(CBITS)) bus ();

    accum_sequencer #(
        .CORES(18), .TRATE(30), .NBITS(5), .TBITS(5),
        .WIDTH(WIDTH), .CBITS(CBITS), .FLUSH(FLUSH)
    ) dut (
        .clock_i (clock_i),
        .reset_i (reset_i),
        .bus     (bus)
    );

    always #5 clock_i = ~clock_i;

    function automatic logic [2*WIDTH-1:0] word_of(input int a);
        return {36'(a * 3 + 7), 36'(a + 100)};
    endfunction

    // SRAM model: data one cycle after the read strobe, junk otherwise.
    always @(posedge clock_i)
        bus.rd_data_i <= bus.rd_en_o ? word_of(int'(bus.rd_addr_o)) : {(2*WIDTH){1'b1}};

    int rdy_mode = 0;
    int sv_mode  = 0;
    initial begin
        bus.m_ready_i = 1'b1;
        bus.s_valid_i = 1'b1;
        forever begin
            @(posedge clock_i); #1;
            bus.m_ready_i = (rdy_mode == 0) ? 1'b1 : ($urandom_range(0, 9) < 3);
            bus.s_valid_i = (sv_mode == 0)  ? 1'b1 : ($urandom_range(0, 1) == 1);
        end
    end

    // Monitor counters, cumulative; tests compare deltas against snapshots.
    int cyc = 0, n_beat = 0, n_clr = 0, n_read = 0, n_word = 0, n_last = 0, n_done = 0;
    int n_addr_err = 0, n_data_err = 0, n_last_err = 0, n_stable_err = 0, n_lat_err = 0;
    int e_addr = 0, e_word = 0, last_beat_cyc = 0;
    bit lat_armed = 0, prev_stall = 0, prev_last = 0;
    logic [2*WIDTH-1:0] prev_data = '0;

    always @(negedge clock_i) begin
        cyc++;
        if (reset_i) begin
            e_addr = 0; e_word = 0; prev_stall = 0; lat_armed = 0;
        end else begin
            if (prev_stall && (!bus.m_valid_o || bus.m_data_o != prev_data || bus.m_last_o != prev_last))
                n_stable_err++;
            if (bus.acc_en_o) begin
                n_beat++;
                if (bus.acc_clr_o) n_clr++;
                if (int'(bus.acc_addr_o) != e_addr) n_addr_err++;
                e_addr = (e_addr == PAIRS - 1) ? 0 : e_addr + 1;
                last_beat_cyc = cyc;
                lat_armed = 1;
            end
            if (bus.rd_en_o) n_read++;
            if (bus.m_valid_o && lat_armed) begin
                if (cyc - last_beat_cyc < FLUSH + 2) n_lat_err++;
                lat_armed = 0;
            end
            if (bus.m_valid_o && bus.m_ready_i) begin
                n_word++;
                if (bus.m_data_o != word_of(e_word)) n_data_err++;
                if (bus.m_last_o != (e_word == PAIRS - 1)) n_last_err++;
                if (bus.m_last_o) n_last++;
                e_word = (e_word == PAIRS - 1) ? 0 : e_word + 1;
            end
            prev_stall = bus.m_valid_o && !bus.m_ready_i;
            prev_data  = bus.m_data_o;
            prev_last  = bus.m_last_o;
            if (bus.done_o) n_done++;
        end
    end

    int total = 0, bad = 0;
    int b_beat, b_clr, b_read, b_word, b_last, b_done, b_ae, b_de, b_le, b_se, b_lat;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic snap();
        b_beat = n_beat; b_clr = n_clr; b_read = n_read; b_word = n_word; b_last = n_last;
        b_done = n_done; b_ae = n_addr_err; b_de = n_data_err; b_le = n_last_err;
        b_se = n_stable_err; b_lat = n_lat_err;
    endtask

    function automatic int outs_nonzero();
        return int'(|{bus.s_ready_o, bus.acc_en_o, bus.acc_clr_o, bus.acc_addr_o, bus.rd_en_o,
                      bus.rd_addr_o, bus.m_valid_o, bus.m_data_o, bus.m_last_o,
                      bus.busy_o, bus.done_o});
    endfunction

    // Starts an integration and waits (bounded) for done_o; optional stray start pulses.
    task automatic run_int(input int frames, input int inj, input int ndone, output int ok);
        bit p1 = 0, p2 = 0;
        int w0 = n_word;
        @(posedge clock_i); #1;
        bus.start_i = 1'b1; bus.frames_i = CBITS'(frames);
        @(posedge clock_i); #1;
        bus.start_i = 1'b0; bus.frames_i = 16'd7;
        ok = 0;
        for (int k = 0; k < 20000; k++) begin
            @(posedge clock_i); #1;
            bus.start_i = 1'b0;
            if (inj != 0 && !p1 && k == 50) begin bus.start_i = 1'b1; bus.frames_i = 16'd9; p1 = 1; end
            if (inj != 0 && !p2 && n_word - w0 >= 5) begin bus.start_i = 1'b1; p2 = 1; end
            if (n_done - b_done >= ndone) begin ok = 1; break; end
        end
        bus.start_i = 1'b0;
    endtask

    typedef struct {
        int frames; int rdy; int sv; int inj; int beats; int clrs;
    } vec_t;
    vec_t tbl [4];

    initial begin
        int ok;
        tbl[0] = '{2, 0, 0, 0, 1080, 540};
        tbl[1] = '{0, 0, 0, 0,  540, 540};
        tbl[2] = '{1, 1, 0, 0,  540, 540};
        tbl[3] = '{3, 1, 1, 1, 1620, 540};

        // Reset held with start_i high: reset wins, everything quiet.
        bus.start_i = 1'b1; bus.frames_i = 16'd1; reset_i = 1'b1;
        repeat (2) @(posedge clock_i);
        @(negedge clock_i);
        check("reset_outputs_zero", outs_nonzero(), 0);
        @(posedge clock_i); #1;
        reset_i = 1'b0; bus.start_i = 1'b0;
        repeat (3) @(negedge clock_i);
        check("start_during_reset_ignored", int'(bus.busy_o), 0);

`ifdef ACC_SEQ_CONTINUOUS_EN
        begin
            int drops = 0;
            snap();
            @(posedge clock_i); #1;
            bus.start_i = 1'b1; bus.frames_i = 16'd1;
            @(posedge clock_i); #1;
            bus.start_i = 1'b0;
            ok = 0;
            for (int k = 0; k < 20000; k++) begin
                @(negedge clock_i);
                if (!bus.busy_o) drops++;
                if (n_done - b_done >= 2) begin ok = 1; break; end
            end
            check("cont_finished", ok, 1);
            check("cont_busy_drops", drops, 0);
            check("cont_beats", n_beat - b_beat, 1080);
            check("cont_clr", n_clr - b_clr, 1080);
            check("cont_words", n_word - b_word, 1080);
            check("cont_done", n_done - b_done, 2);
            check("cont_data_err", n_data_err - b_de, 0);
            @(posedge clock_i); #1; reset_i = 1'b1;
            @(posedge clock_i); #1; reset_i = 1'b0;
        end
`else
        // Reset in the middle of a drain.
        snap();
        @(posedge clock_i); #1;
        bus.start_i = 1'b1; bus.frames_i = 16'd1;
        @(posedge clock_i); #1;
        bus.start_i = 1'b0;
        ok = 0;
        for (int k = 0; k < 5000; k++) begin
            @(posedge clock_i); #1;
            if (n_word - b_word >= 20) begin ok = 1; break; end
        end
        check("drain_reached", ok, 1);
        reset_i = 1'b1;
        repeat (2) @(posedge clock_i);
        @(negedge clock_i);
        check("middrain_reset_outputs_zero", outs_nonzero(), 0);
        check("middrain_reset_busy", int'(bus.busy_o), 0);
        @(posedge clock_i); #1;
        reset_i = 1'b0;
        repeat (3) @(posedge clock_i);

        for (int v = 0; v < 4; v++) begin
            rdy_mode = tbl[v].rdy;
            sv_mode  = tbl[v].sv;
            snap();
            run_int(tbl[v].frames, tbl[v].inj, 1, ok);
            repeat (6) @(posedge clock_i);
            @(negedge clock_i);
            check($sformatf("v%0d_finished", v), ok, 1);
            check($sformatf("v%0d_beats", v), n_beat - b_beat, tbl[v].beats);
            check($sformatf("v%0d_clr", v), n_clr - b_clr, tbl[v].clrs);
            check($sformatf("v%0d_reads", v), n_read - b_read, PAIRS);
            check($sformatf("v%0d_words", v), n_word - b_word, PAIRS);
            check($sformatf("v%0d_last", v), n_last - b_last, 1);
            check($sformatf("v%0d_done", v), n_done - b_done, 1);
            check($sformatf("v%0d_addr_err", v), n_addr_err - b_ae, 0);
            check($sformatf("v%0d_data_err", v), n_data_err - b_de, 0);
            check($sformatf("v%0d_last_err", v), n_last_err - b_le, 0);
            check($sformatf("v%0d_stall_stable", v), n_stable_err - b_se, 0);
            check($sformatf("v%0d_latency", v), n_lat_err - b_lat, 0);
            check($sformatf("v%0d_idle_after", v), int'(bus.busy_o), 0);
        end
        rdy_mode = 0;
        sv_mode  = 0;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
